// File: rtl/param_stack.sv
// ---------------------------------------------------------------------------
// param_stack
// Parameterised LIFO stack with a registered top-of-stack peek, occupancy
// count, high-water mark and sticky overflow/underflow flags.
//
// Ports
//   CLK        in   1      clock, all state changes on the rising edge
//   RST        in   1      synchronous active-high reset
//   PUSH       in   1      push request
//   POP        in   1      pop request
//   CLEAR      in   1      synchronous flush of the contents (keeps HWM/flags)
//   ERR_CLR    in   1      clears the sticky error flags
//   DATA_IN    in   WIDTH  word to push
//   DATA_OUT   out  WIDTH  registered top of stack, 0 when empty
//   COUNT      out  CNT_W  current occupancy 0..DEPTH
//   HWM        out  CNT_W  highest occupancy seen since reset
//   FULL       out  1      COUNT == DEPTH
//   EMPTY      out  1      COUNT == 0
//   OVERFLOW   out  1      sticky: a push was rejected while full
//   UNDERFLOW  out  1      sticky: a pop was rejected while empty
// ---------------------------------------------------------------------------
module param_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PUSH,
    input  logic             POP,
    input  logic             CLEAR,
    input  logic             ERR_CLR,
    input  logic [WIDTH-1:0] DATA_IN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic [CNT_W-1:0] COUNT,
    output logic [CNT_W-1:0] HWM,
    output logic             FULL,
    output logic             EMPTY,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Storage is deliberately not reset; DATA_OUT is tracked separately so
    // stale entries can never leak out.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_hwm;
    logic [WIDTH-1:0] r_dout;
    logic             r_ovf;
    logic             r_unf;

    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_dout_nxt;
    logic             w_wr_en;
    logic [IDX_W-1:0] w_wr_idx;
    logic [IDX_W-1:0] w_rd_idx;
    logic             w_ovf_set;
    logic             w_unf_set;

    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == {CNT_W{1'b0}});
    // Entry just below the current top; becomes the new top after a pop.
    assign w_rd_idx = IDX_W'(r_count - CNT_W'(2));

    // Next-state decode for count, peek register, storage write and error events
    always_comb begin
        w_count_nxt = r_count;
        w_dout_nxt  = r_dout;
        w_wr_en     = 1'b0;
        w_wr_idx    = IDX_W'(r_count);
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
        if (CLEAR) begin
            w_count_nxt = {CNT_W{1'b0}};
            w_dout_nxt  = {WIDTH{1'b0}};
        end else begin
            case ({PUSH, POP})
                2'b10: begin
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_wr_en     = 1'b1;
                        w_wr_idx    = IDX_W'(r_count);
                        w_count_nxt = r_count + CNT_W'(1);
                        w_dout_nxt  = DATA_IN;
                    end
                end
                2'b01: begin
                    if (w_empty) begin
                        w_unf_set = 1'b1;
                    end else begin
                        w_count_nxt = r_count - CNT_W'(1);
                        if (r_count >= CNT_W'(2)) begin
                            w_dout_nxt = r_mem[w_rd_idx];
                        end else begin
                            w_dout_nxt = {WIDTH{1'b0}};
                        end
                    end
                end
                2'b11: begin
                    // Simultaneous push/pop replaces the top; on an empty
                    // stack it degenerates to a plain push.
                    w_wr_en    = 1'b1;
                    w_dout_nxt = DATA_IN;
                    if (w_empty) begin
                        w_wr_idx    = {IDX_W{1'b0}};
                        w_count_nxt = CNT_W'(1);
                    end else begin
                        w_wr_idx    = IDX_W'(r_count - CNT_W'(1));
                        w_count_nxt = r_count;
                    end
                end
                default: begin
                    w_count_nxt = r_count;
                end
            endcase
        end
    end

    // Storage write port (no reset on the array)
    always_ff @(posedge CLK) begin
        if (!RST && w_wr_en) begin
            r_mem[w_wr_idx] <= DATA_IN;
        end
    end

    // Control state: occupancy, peek, high-water mark and sticky flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_count <= {CNT_W{1'b0}};
            r_hwm   <= {CNT_W{1'b0}};
            r_dout  <= {WIDTH{1'b0}};
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_dout  <= w_dout_nxt;
            if (w_count_nxt > r_hwm) begin
                r_hwm <= w_count_nxt;
            end
            // A new error in the same cycle as ERR_CLR keeps the flag set.
            r_ovf <= w_ovf_set | (r_ovf & ~ERR_CLR);
            r_unf <= w_unf_set | (r_unf & ~ERR_CLR);
        end
    end

    assign DATA_OUT  = r_dout;
    assign COUNT     = r_count;
    assign HWM       = r_hwm;
    assign FULL      = w_full;
    assign EMPTY     = w_empty;
    assign OVERFLOW  = r_ovf;
    assign UNDERFLOW = r_unf;

endmodule

// File: tb/tb_param_stack.sv
// ---------------------------------------------------------------------------
// tb_param_stack
// Self-checking bench for param_stack (WIDTH=4, DEPTH=8). A queue-based
// reference stack predicts the outputs of every cycle; predictions are pushed
// into a scoreboard when stimulus is driven and popped/compared one cycle
// later when the DUT has registered the result.
// ---------------------------------------------------------------------------
module tb_param_stack;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             push;
    logic             pop;
    logic             clear;
    logic             err_clr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] hwm;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             underflow;

    param_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (clk),
        .RST       (rst),
        .PUSH      (push),
        .POP       (pop),
        .CLEAR     (clear),
        .ERR_CLR   (err_clr),
        .DATA_IN   (data_in),
        .DATA_OUT  (data_out),
        .COUNT     (count),
        .HWM       (hwm),
        .FULL      (full),
        .EMPTY     (empty),
        .OVERFLOW  (overflow),
        .UNDERFLOW (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int dout;
        int cnt;
        int hwm;
        int full;
        int empty;
        int ovf;
        int unf;
    } exp_t;

    exp_t exp_q[$];
    int   m_stack[$];
    int   m_hwm;
    int   m_ovf;
    int   m_unf;
    int   checks_s;
    int   failures_s;

    task automatic check_val(input string tag, input int act, input int exp);
        checks_s++;
        if (act != exp) begin
            failures_s++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive one cycle, predict its result, then compare after the edge.
    task automatic step(input bit r, input bit pu, input bit po, input bit cl,
                        input bit ec, input int din);
        exp_t e;
        bit   os;
        bit   us;
        rst = r; push = pu; pop = po; clear = cl; err_clr = ec;
        data_in = WIDTH'(din);
        os = 1'b0;
        us = 1'b0;
        if (r) begin
            m_stack.delete();
            m_hwm = 0; m_ovf = 0; m_unf = 0;
        end else begin
            if (cl) begin
                m_stack.delete();
            end else if (pu && po) begin
                if (m_stack.size() == 0) m_stack.push_back(din);
                else m_stack[m_stack.size() - 1] = din;
            end else if (pu) begin
                if (m_stack.size() == DEPTH) os = 1'b1;
                else m_stack.push_back(din);
            end else if (po) begin
                if (m_stack.size() == 0) us = 1'b1;
                else void'(m_stack.pop_back());
            end
            if (ec) begin
                m_ovf = 0; m_unf = 0;
            end
            if (os) m_ovf = 1;
            if (us) m_unf = 1;
            if (m_stack.size() > m_hwm) m_hwm = m_stack.size();
        end
        e.cnt   = m_stack.size();
        e.dout  = (m_stack.size() == 0) ? 0 : m_stack[m_stack.size() - 1];
        e.hwm   = m_hwm;
        e.full  = (e.cnt == DEPTH) ? 1 : 0;
        e.empty = (e.cnt == 0) ? 1 : 0;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_val("dout",  int'(data_out),  e.dout);
        check_val("count", int'(count),     e.cnt);
        check_val("hwm",   int'(hwm),       e.hwm);
        check_val("full",  int'(full),      e.full);
        check_val("empty", int'(empty),     e.empty);
        check_val("ovf",   int'(overflow),  e.ovf);
        check_val("unf",   int'(underflow), e.unf);
    endtask

    initial begin
        checks_s = 0;
        failures_s = 0;
        m_hwm = 0; m_ovf = 0; m_unf = 0;
        rst = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0;
        data_in = '0;
        @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, 0);
        check_val("rst_empty", int'(empty), 1);

        // Fill 1..8, then overflow push of 0xF
        for (int i = 1; i <= 8; i++) step(0, 1, 0, 0, 0, i);
        check_val("fill_full", int'(full), 1);
        check_val("fill_hwm", int'(hwm), 8);
        step(0, 1, 0, 0, 0, 15);
        check_val("ovf_dout", int'(data_out), 8);
        check_val("ovf_flag", int'(overflow), 1);

        // Drain, extra pop, error clear
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0, 0);
        check_val("drain_dout", int'(data_out), 0);
        step(0, 0, 1, 0, 0, 0);
        check_val("unf_flag", int'(underflow), 1);
        step(0, 0, 0, 0, 1, 0);
        check_val("errclr_unf", int'(underflow), 0);
        check_val("errclr_hwm", int'(hwm), 8);

        // Replace on {3,5}, then pop, then replace while full
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 3);
        step(0, 1, 0, 0, 0, 5);
        step(0, 1, 1, 0, 0, 10);
        check_val("repl_dout", int'(data_out), 10);
        step(0, 0, 1, 0, 0, 0);
        check_val("repl_pop", int'(data_out), 3);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0, 0, i + 2);
        step(0, 1, 1, 0, 0, 12);
        check_val("repl_full_ovf", int'(overflow), 0);

        // Push+pop on empty
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 6);
        check_val("pp_empty_dout", int'(data_out), 6);

        // Clear with push, then error-clear colliding with an overflow
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, i + 1);
        step(0, 1, 0, 1, 0, 9);
        check_val("clr_hwm", int'(hwm), 4);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, i);
        step(0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1, 2);
        check_val("ec_ovf_wins", int'(overflow), 1);

        // Reset mid-operation with push active, then pop
        step(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 0, i + 7);
        step(1, 1, 0, 0, 0, 4);
        check_val("midrst_hwm", int'(hwm), 0);
        step(0, 0, 1, 0, 0, 0);
        check_val("midrst_unf", int'(underflow), 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 2) == 0, ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_s, failures_s);
        $finish;
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries (>=2, need not be a power of two).
REQ-003 Derived localparam CNT_W = $clog2(DEPTH+1), width of occupancy outputs; not user-overridable.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 PUSH  input  1  push request.
REQ-007 POP  input  1  pop request.
REQ-008 CLEAR  input  1  synchronous flush of stack contents.
REQ-009 ERR_CLR  input  1  clears sticky error flags.
REQ-010 DATA_IN  input  WIDTH  word to push.
REQ-011 DATA_OUT  output  WIDTH  registered top-of-stack (peek); 0 when empty.
REQ-012 COUNT  output  CNT_W  current occupancy, 0..DEPTH.
REQ-013 HWM  output  CNT_W  high-water mark, max COUNT since reset.
REQ-014 FULL  output  1  COUNT == DEPTH.
REQ-015 EMPTY  output  1  COUNT == 0.
REQ-016 OVERFLOW  output  1  sticky: push rejected while full.
REQ-017 UNDERFLOW  output  1  sticky: pop rejected while empty.

Function
REQ-018 All outputs registered or decoded from registered state only; no combinational path from inputs to outputs.
REQ-019 Per-cycle priority: RST > CLEAR > PUSH/POP.
REQ-020 PUSH only, not full: DATA_IN stored at top, COUNT+1, DATA_OUT = DATA_IN from next cycle.
REQ-021 POP only, not empty: top removed, COUNT-1, DATA_OUT = new top next cycle (0 if now empty).
REQ-022 PUSH and POP same cycle, not empty (incl. full): top replaced by DATA_IN, COUNT unchanged, DATA_OUT = DATA_IN next cycle, no flag set.
REQ-023 PUSH and POP same cycle, empty: treated as PUSH only; UNDERFLOW not set.
REQ-024 PUSH only while full: ignored, contents/COUNT unchanged, OVERFLOW set next cycle.
REQ-025 POP only while empty: ignored, UNDERFLOW set next cycle.
REQ-026 CLEAR: COUNT->0, DATA_OUT->0, EMPTY->1 next cycle; PUSH/POP that cycle ignored and raise no flags; HWM and sticky flags unaffected.
REQ-027 ERR_CLR clears OVERFLOW and UNDERFLOW next cycle; a new error in the same cycle wins (flag remains/becomes 1).
REQ-028 HWM updates to COUNT's next value whenever that exceeds HWM; cleared only by RST.
REQ-029 FULL/EMPTY valid in same cycle as COUNT; never both 1.
REQ-030 Storage array is not reset; stale entries never visible on DATA_OUT.

Reset
REQ-031 RST sampled high: next cycle COUNT=0, HWM=0, DATA_OUT=0, EMPTY=1, FULL=0, OVERFLOW=0, UNDERFLOW=0; all other inputs ignored that cycle.
REQ-032 RST mid-operation (stack partly full, any inputs active) yields identical post-reset state as REQ-031; first operation after reset behaves as on an empty stack.

Verification (WIDTH=4, DEPTH=8)
REQ-033 Push 1..8 on consecutive cycles -> COUNT 1..8, DATA_OUT follows 1..8, FULL=1 after 8th, HWM=8; 9th push of 0xF -> OVERFLOW=1, DATA_OUT=8, COUNT=8.
REQ-034 From full, pop 8 times -> DATA_OUT 7,6,...,1,0, EMPTY=1 after last; extra pop -> UNDERFLOW=1, COUNT=0; ERR_CLR -> UNDERFLOW=0, OVERFLOW=0, HWM stays 8.
REQ-035 Stack {3,5}, PUSH+POP with DATA_IN=0xA -> COUNT=2, DATA_OUT=0xA; then POP -> DATA_OUT=3; PUSH+POP when full -> no OVERFLOW.
REQ-036 Empty stack, PUSH+POP with DATA_IN=0x6 -> COUNT=1, DATA_OUT=6, UNDERFLOW=0.
REQ-037 Stack of 4, CLEAR with PUSH asserted -> COUNT=0, DATA_OUT=0, HWM=4, no flags; same-cycle ERR_CLR and overflow push -> OVERFLOW=1.
REQ-038 RST asserted with COUNT=5 and PUSH high -> all outputs at REQ-031 values; subsequent POP -> UNDERFLOW=1.
